// File: rtl/ram_fifo_pkg.sv
// ============================================================================
// ram_fifo_pkg : width helpers shared by the RAM-backed FWFT FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

package ram_fifo_pkg;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Room for DEPTH RAM entries plus the head register
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/SyncRam1r1w.sv
// ============================================================================
// SyncRam1r1w : 1R1W storage with registered read; rdata holds while re=0
// Rev 1.0
// ============================================================================
`default_nettype none

module SyncRam1r1w #(
    parameter int RAM_DATA_WIDTH = 32,
    parameter int RAM_DEPTH      = 512,
    parameter int RAM_ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      we,
    input  logic [RAM_ADDR_WIDTH-1:0] waddr,
    input  logic [RAM_DATA_WIDTH-1:0] wdata,
    input  logic                      re,
    input  logic [RAM_ADDR_WIDTH-1:0] raddr,
    output logic [RAM_DATA_WIDTH-1:0] rdata
);

    logic [RAM_DATA_WIDTH-1:0] mem [RAM_DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < RAM_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            if (re) begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_fifo_ptr.sv
// ============================================================================
// ram_fifo_ptr : wrap-bit write/read pointer pair with RAM occupancy flags
// Rev 1.0
// ============================================================================
`default_nettype none

module ram_fifo_ptr
    import ram_fifo_pkg::*;
#(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              i_rstn,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] raddr,
    output logic [ADDR_W:0]   ram_cnt,
    output logic              full,
    output logic              empty
);

    logic [ADDR_W:0] wptr;
    logic [ADDR_W:0] rptr;

    always_ff @(posedge clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    assign waddr   = wptr[ADDR_W-1:0];
    assign raddr   = rptr[ADDR_W-1:0];
    assign ram_cnt = wptr - rptr;
    // Same slot, opposite lap: the RAM holds DEPTH entries
    assign full    = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                     (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    assign empty   = (wptr == rptr);

endmodule

`default_nettype wire

// File: rtl/ram_fifo.sv
// ============================================================================
// ram_fifo : first-word-fall-through valid/ready FIFO on SyncRam1r1w storage
// Rev 1.0
// ============================================================================
`default_nettype none

module ram_fifo
    import ram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 512,
    parameter int AFULL_THRESH = DEPTH - 4
) (
    input  logic                       clk,
    input  logic                       i_rstn,
    input  logic                       i_flush,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [DATA_WIDTH-1:0]      i_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [DATA_WIDTH-1:0]      o_data,
    output logic [cnt_w(DEPTH)-1:0]    o_count,
    output logic                       o_almost_full,
    output logic                       o_empty
);

    localparam int ADDR_W = addr_w(DEPTH);
    localparam int CNT_W  = cnt_w(DEPTH);

    logic              push;
    logic              re;
    logic              ram_full;
    logic              ram_empty;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr;
    logic [ADDR_W:0]   ram_cnt;

    assign o_ready = !ram_full;
    assign push    = i_valid && o_ready && !i_flush;
    // Refill the head whenever it is empty or being consumed this cycle
    assign re      = !ram_empty && (!o_valid || i_ready) && !i_flush;

    ram_fifo_ptr #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ptr (
        .clk     (clk),
        .i_rstn  (i_rstn),
        .flush   (i_flush),
        .push    (push),
        .pop     (re),
        .waddr   (waddr),
        .raddr   (raddr),
        .ram_cnt (ram_cnt),
        .full    (ram_full),
        .empty   (ram_empty)
    );

    SyncRam1r1w #(
        .RAM_DATA_WIDTH (DATA_WIDTH),
        .RAM_DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rstn  (i_rstn),
        .we    (push),
        .waddr (waddr),
        .wdata (i_data),
        .re    (re),
        .raddr (raddr),
        .rdata (o_data)
    );

    always_ff @(posedge clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_valid <= 1'b0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (re) begin
            o_valid <= 1'b1;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

    assign o_count       = CNT_W'(ram_cnt) + CNT_W'(o_valid);
    assign o_almost_full = (o_count >= CNT_W'(AFULL_THRESH));
    assign o_empty       = (o_count == '0);

endmodule

`default_nettype wire

// File: tb/tb_ram_fifo.sv
// ============================================================================
// tb_ram_fifo : directed vector table plus hand sequences for ram_fifo
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ram_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AF    = 4;
    localparam int CW    = 4;

    logic          clk;
    logic          i_rstn;
    logic          i_flush;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
    logic [CW-1:0] o_count;
    logic          o_almost_full;
    logic          o_empty;

    int n_cmp;
    int n_bad;

    ram_fifo #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AF)
    ) dut (
        .clk           (clk),
        .i_rstn        (i_rstn),
        .i_flush       (i_flush),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_data        (i_data),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_data        (o_data),
        .o_count       (o_count),
        .o_almost_full (o_almost_full),
        .o_empty       (o_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        r;
        logic [31:0] d;
        logic        e_ready;
        logic        e_valid;
        logic [31:0] e_data;
        int          e_count;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic r, input logic [31:0] d,
                       input logic er, input logic ev, input logic [31:0] ed, input int ec);
        vec_t x;
        x.v = v; x.r = r; x.d = d;
        x.e_ready = er; x.e_valid = ev; x.e_data = ed; x.e_count = ec;
        vecs.push_back(x);
    endtask

    task automatic check_state(input string tag, input logic er, input logic ev, input int ec);
        check({tag, ".ready"}, {31'd0, o_ready}, {31'd0, er});
        check({tag, ".valid"}, {31'd0, o_valid}, {31'd0, ev});
        check({tag, ".count"}, {28'd0, o_count}, ec);
        check({tag, ".afull"}, {31'd0, o_almost_full}, {31'd0, (ec >= AF)});
        check({tag, ".empty"}, {31'd0, o_empty}, {31'd0, (ec == 0)});
    endtask

    task automatic do_reset();
        i_rstn  = 1'b0;
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        repeat (2) @(negedge clk);
        i_rstn = 1'b1;
    endtask

    logic [31:0] q[$];
    logic [31:0] exp_d;
    logic [31:0] prev_d;
    logic        hold;
    int          seen;
    int          budget;

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // Fill to DEPTH+1 with consumer stalled, hold off a 10th push, then drain
        for (int k = 0; k < 9; k++) add(1, 0, k + 1, 1, (k >= 2), 1, k);
        add(1, 0, 10, 0, 1, 1, 9);
        add(1, 1, 10, 0, 1, 1, 9);
        add(1, 0, 10, 1, 1, 2, 8);
        for (int j = 0; j < 9; j++) add(0, 1, 0, (j != 0), 1, 2 + j, 9 - j);
        add(0, 0, 0, 1, 0, 0, 0);

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            i_valid = vecs[i].v;
            i_ready = vecs[i].r;
            i_data  = vecs[i].d;
            check_state($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_valid, vecs[i].e_count);
            if (vecs[i].e_valid)
                check($sformatf("vec%0d.data", i), o_data, vecs[i].e_data);
        end

        // Single push: 2-cycle write-to-visible latency
        do_reset();
        @(negedge clk);
        check_state("rst", 1, 0, 0);
        i_valid = 1; i_data = 32'hA5A5_0001;
        @(negedge clk);
        i_valid = 0;
        check_state("single.c1", 1, 0, 1);
        @(negedge clk);
        check_state("single.c2", 1, 1, 1);
        check("single.data", o_data, 32'hA5A5_0001);
        i_ready = 1;
        @(negedge clk);
        i_ready = 0;
        check_state("single.c3", 1, 0, 0);

        // Streaming with wrap-around, must be gapless once the head fills
        do_reset();
        exp_d = 0;
        i_ready = 1;
        for (int c = 0; c < 1010; c++) begin
            @(negedge clk);
            if (o_valid) begin
                check("stream.data", o_data, exp_d);
                exp_d++;
            end else if (exp_d > 0 && exp_d < 1000) begin
                check("stream.gap", {31'd0, o_valid}, 32'd1);
            end
            i_valid = (c < 1000);
            i_data  = c;
        end
        i_valid = 0;
        check("stream.total", exp_d, 32'd1000);

        // Random producer/consumer against a queue model
        do_reset();
        q.delete();
        hold = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            check("rand.count", {28'd0, o_count}, q.size());
            if (hold) begin
                check("rand.hold_valid", {31'd0, o_valid}, 32'd1);
                check("rand.hold_data", o_data, prev_d);
            end
            i_valid = (c < 560) ? 1'($urandom_range(0, 1)) : 1'b0;
            i_ready = (c < 560) ? 1'($urandom_range(0, 1)) : 1'b1;
            i_data  = $urandom;
            if (o_valid && i_ready) begin
                if (q.size() == 0) check("rand.underflow", 32'd1, 32'd0);
                else check("rand.data", o_data, q.pop_front());
            end
            if (i_valid && o_ready) q.push_back(i_data);
            hold   = o_valid && !i_ready;
            prev_d = o_data;
        end
        @(negedge clk);
        check("rand.drained", {31'd0, o_empty}, 32'd1);
        i_ready = 0;

        // Flush with 5 entries held and concurrent push/pop
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            i_valid = 1; i_data = 32'h100 + k;
        end
        @(negedge clk);
        check_state("flush.pre", 1, 1, 5);
        i_flush = 1; i_valid = 1; i_ready = 1; i_data = 32'hDEAD;
        @(negedge clk);
        i_flush = 0; i_ready = 0; i_data = 32'h77;
        check_state("flush.post", 1, 0, 0);
        @(negedge clk);
        i_valid = 0;
        check_state("flush.p1", 1, 0, 1);
        @(negedge clk);
        check_state("flush.p2", 1, 1, 1);
        check("flush.data", o_data, 32'h77);
        i_ready = 1;
        @(negedge clk);
        i_ready = 0;
        check_state("flush.p3", 1, 0, 0);

        // Asynchronous reset pulse in the middle of traffic
        i_ready = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            i_valid = 1; i_data = 32'h200 + k;
        end
        @(posedge clk);
        #2 i_rstn = 0;
        #2 check_state("areset", 1, 0, 0);
        @(negedge clk);
        i_rstn = 1; i_valid = 1; i_data = 32'h55;
        @(negedge clk);
        i_valid = 0;
        seen = 0;
        budget = 0;
        while (!o_valid && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        check("areset.timeout", {31'd0, o_valid}, 32'd1);
        check("areset.count", {28'd0, o_count}, 32'd1);
        check("areset.data", o_data, 32'h55);
        i_ready = 1;
        @(negedge clk);
        i_ready = 0;
        check_state("areset.end", 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ram_fifo.md
Name: ram_fifo

Overview:
- Synchronous first-word-fall-through FIFO built around the team's SyncRam1r1w storage macro (1-cycle registered read, rdata holds when re=0).
- Converts the raw we/re/address RAM interface into valid/ready streams on both sides.
- Sits between a producer (e.g. fetch/issue queue writer) and a consumer stage.
- RAM rdata is used directly as the output holding register, so no extra data flop is needed.

Parameters:
- DATA_WIDTH, 32, payload width; passed to the RAM as RAM_DATA_WIDTH.
- DEPTH, 512, RAM entries; passed as RAM_DEPTH; must be a power of two, >= 4.
- AFULL_THRESH, DEPTH-4, o_almost_full asserts when o_count >= AFULL_THRESH.

Ports:
- clk  input  1  clock
- i_rstn  input  1  reset
- i_flush  input  1  synchronous flush; discards all contents
- i_valid  input  1  write request
- o_ready  output  1  FIFO can accept a write
- i_data  input  DATA_WIDTH  write payload
- o_valid  output  1  head entry available on o_data
- i_ready  input  1  consumer takes head
- o_data  output  DATA_WIDTH  head payload (RAM rdata)
- o_count  output  $clog2(DEPTH+2)  total entries held (RAM + head)
- o_almost_full  output  1  o_count >= AFULL_THRESH
- o_empty  output  1  o_count == 0

Behaviour:
- Reset: i_rstn, asynchronous, active-low; clock clk. Reset clears wptr, rptr, ram_cnt, o_valid, and the RAM contents.
- Outputs after reset: o_ready=1, o_valid=0, o_count=0, o_empty=1, o_almost_full=0.
- o_data is don't-care whenever o_valid=0.
- Pointers:
  - wptr/rptr are ADDR_W+1 bits, with the MSB as wrap bit.
  - ram_cnt = wptr - rptr.
  - RAM full when the MSBs differ and the low bits are equal; RAM empty when the pointers are equal.
- Push:
  - push = i_valid & o_ready, where o_ready = !ram_full (registered-state only, no comb path from i_ready).
  - On push: we=1, waddr=wptr[ADDR_W-1:0], wptr++.
- Read issue:
  - re = !ram_empty & (!o_valid | i_ready).
  - On re: raddr=rptr low bits, rptr++, and o_valid<=1 next cycle.
  - Else if o_valid & i_ready: o_valid<=0.
  - Else o_valid holds, and o_data holds because the RAM keeps rdata while re=0.
- Capacity is DEPTH+1 (DEPTH in RAM plus 1 head); o_count = ram_cnt + o_valid.
- Latency:
  - Push at edge t into an empty FIFO gives ram_cnt=1 in cycle t+1 and re asserted in t+1.
  - o_valid=1 with the data in cycle t+2 (2-cycle write-to-visible).
  - Back-to-back pop with a non-empty RAM sustains 1 entry/cycle.
- Read/write address collision never occurs: re requires ram_cnt>0 from registered state, so the location being written is never read in the same cycle.
- Simultaneous push and re: ram_cnt unchanged, both pointers advance.
- Push while full: o_ready=0, so the write is ignored even if a pop occurs that cycle; it is accepted next cycle.
- Wrap-around: pointers wrap naturally at 2*DEPTH; data order is preserved across the wrap.
- i_flush:
  - Highest priority; next cycle wptr=rptr=0 and o_valid=0.
  - we and re are forced to 0 in the flush cycle; RAM contents are not cleared.
- Reset mid-operation: all state returns to reset values immediately (async); in-flight data is lost.

Decomposition:
- Shared package ram_fifo_pkg:
  - function for ADDR_W = $clog2(DEPTH);
  - count-width function;
  - no typedefs needed beyond a parameterised data word.
- One natural sub-module: ram_fifo_ptr (pointer pair, full/empty/count logic).
- Storage is a direct instance of SyncRam1r1w.

Test Plan:
- Reset then single push 0xA5A5_0001 at cycle 0 -> o_valid rises at cycle 2 with o_data=0xA5A5_0001, o_count=1; pop -> o_empty=1 next cycle.
- Streaming: push 0..999 continuously with i_ready=1, DEPTH=8 -> output sequence 0..999 in order, no gaps after the initial 2-cycle fill, pointers wrap more than 100 times.
- Fill with i_ready=0, DEPTH=8:
  - 9 pushes accepted and o_ready=0 after the 9th, with o_count=9;
  - 10th push held off;
  - one pop -> o_ready=1 next cycle and the 10th push is accepted;
  - o_almost_full asserts at count 4 (AFULL_THRESH=4).
- Consumer stall with i_ready toggling randomly 50% and random i_valid -> scoreboard match, o_data stable while o_valid & !i_ready.
- i_flush asserted with 5 entries and o_valid=1, concurrent push/pop -> next cycle o_count=0, o_valid=0; subsequent push 0x77 emerges 2 cycles later as the only entry.
- Async reset pulse mid-stream (i_rstn low 3 ns between edges) -> outputs return to reset values immediately; post-reset push/pop works and no stale data appears.
